// File: rtl/fifo_flex.sv
// Single-clock FIFO with selectable standard/FWFT read, almost thresholds,
// occupancy count and sticky overflow/underflow flags cleared by clr_err.
module fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit FWFT       = 1'b0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         clr_err,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  // Flags decode the registered count, so they lag an operation by one cycle.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A fresh error event outranks a clear in the same cycle.
    if (wr_en & full & ~rd_en) overflow_d = 1'b1;
    else if (clr_err)          overflow_d = 1'b0;

    if (rd_en & empty)         underflow_d = 1'b1;
    else if (clr_err)          underflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ && wr_acc) mem_q[wr_ptr_q] <= din;
  end

  if (FWFT) begin : g_fwft
    assign dout = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (rst_)        dout_q <= '0;
      else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
    end
    assign dout = dout_q;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench: three fifo_flex instances (16/std, 16/FWFT, 5/std) share one
// stimulus stream and are each compared against a queue-based reference model.
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] dout0, dout1, dout2;
  logic [4:0] cnt0, cnt1;
  logic [2:0] cnt2;
  logic       f0, e0, af0, ae0, ov0, un0;
  logic       f1, e1, af1, ae1, ov1, un1;
  logic       f2, e2, af2, ae2, ov2, un2;

  always #5 clk = ~clk;

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0)) u0 (
    .clk(clk), .rst_(rst_), .wr_en(wr_en), .rd_en(rd_en), .din(din), .clr_err(clr_err),
    .dout(dout0), .full(f0), .empty(e0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ov0), .underflow(un0));

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b1)) u1 (
    .clk(clk), .rst_(rst_), .wr_en(wr_en), .rd_en(rd_en), .din(din), .clr_err(clr_err),
    .dout(dout1), .full(f1), .empty(e1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ov1), .underflow(un1));

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1'b0)) u2 (
    .clk(clk), .rst_(rst_), .wr_en(wr_en), .rd_en(rd_en), .din(din), .clr_err(clr_err),
    .dout(dout2), .full(f2), .empty(e2), .almost_full(af2), .almost_empty(ae2),
    .count(cnt2), .overflow(ov2), .underflow(un2));

  int dep [3] = '{16, 16, 5};
  int afl [3] = '{14, 14, 3};
  int ael [3] = '{2, 2, 2};

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [7:0] sb0 [$];
  logic [7:0] sb2 [$];
  bit         m_ov [3];
  bit         m_un [3];
  logic [7:0] hold [3];
  bit         fire_q [3];
  bit         rstp [3];
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue per instance, updated on each rising edge.
  task automatic model_step(input int k);
    logic [7:0] t [$];
    logic [7:0] v;
    bit fm, em, wacc, racc;
    case (k)
      0:       t = q0;
      1:       t = q1;
      default: t = q2;
    endcase
    fm = (t.size() == dep[k]);
    em = (t.size() == 0);
    if (rst_) begin
      t.delete();
      m_ov[k] = 1'b0;
      m_un[k] = 1'b0;
    end else begin
      wacc = wr_en && (!fm || rd_en);
      racc = rd_en && !em;
      if (racc) begin
        v = t.pop_front();
        if (k == 0) sb0.push_back(v);
        else if (k == 2) sb2.push_back(v);
      end
      if (wacc) t.push_back(din);
      if (wr_en && fm && !rd_en) m_ov[k] = 1'b1;
      else if (clr_err)          m_ov[k] = 1'b0;
      if (rd_en && em)           m_un[k] = 1'b1;
      else if (clr_err)          m_un[k] = 1'b0;
    end
    case (k)
      0:       q0 = t;
      1:       q1 = t;
      default: q2 = t;
    endcase
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  task automatic check_inst(input int k, input logic [7:0] d, input logic [4:0] cnt,
                            input logic f, input logic e, input logic af, input logic ae,
                            input logic ov, input logic un);
    logic [7:0] t [$];
    logic [7:0] v;
    int sz;
    bit got;
    case (k)
      0:       t = q0;
      1:       t = q1;
      default: t = q2;
    endcase
    sz = t.size();
    chk("count", k, 32'(cnt), 32'(sz));
    chk("full", k, 32'(f), 32'(sz == dep[k]));
    chk("empty", k, 32'(e), 32'(sz == 0));
    chk("almost_full", k, 32'(af), 32'(sz >= afl[k]));
    chk("almost_empty", k, 32'(ae), 32'(sz <= ael[k]));
    chk("overflow", k, 32'(ov), 32'(m_ov[k]));
    chk("underflow", k, 32'(un), 32'(m_un[k]));
    if (k == 1) begin
      v = (sz > 0) ? t[0] : 8'h00;
      chk("dout_fwft", k, 32'(d), 32'(v));
    end else begin
      if (fire_q[k]) begin
        got = 1'b0;
        if (k == 0 && sb0.size() > 0) begin v = sb0.pop_front(); got = 1'b1; end
        if (k == 2 && sb2.size() > 0) begin v = sb2.pop_front(); got = 1'b1; end
        if (got) hold[k] = v;
        else begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty u%0d t=%0t: got read with no expected word", k, $time);
        end
      end else if (rstp[k]) begin
        hold[k] = 8'h00;
      end
      chk("dout", k, 32'(d), 32'(hold[k]));
    end
    // Inputs are already set up for the next edge; note whether it pops.
    fire_q[k] = !rst_ && rd_en && !e;
    rstp[k]   = rst_;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_inst(0, dout0, cnt0, f0, e0, af0, ae0, ov0, un0);
      check_inst(1, dout1, cnt1, f1, e1, af1, ae1, ov1, un1);
      check_inst(2, dout2, 5'(cnt2), f2, e2, af2, ae2, ov2, un2);
    end
  end

  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input logic c, input logic rs);
    wr_en   = w;
    rd_en   = r;
    din     = d;
    clr_err = c;
    rst_    = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      hold[k] = 8'h00; fire_q[k] = 1'b0; rstp[k] = 1'b1; m_ov[k] = 1'b0; m_un[k] = 1'b0;
    end
    step(0, 0, 8'h00, 0, 1);
    mon_en = 1'b1;
    step(0, 0, 8'h00, 0, 1);

    for (int i = 1; i <= 16; i++) step(1, 0, 8'(i), 0, 0);
    step(1, 0, 8'h11, 0, 0);
    step(1, 1, 8'hAA, 0, 0);
    repeat (16) step(0, 1, 8'h00, 0, 0);

    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 1, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);

    step(1, 0, 8'h5C, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);

    for (int i = 0; i < 12; i++) begin
      step(1, 0, 8'($urandom_range(0, 255)), 0, 0);
      step(0, 1, 8'h00, 0, 0);
    end

    for (int i = 0; i < 600; i++) begin
      logic w, r, c, rs;
      w  = ($urandom_range(0, 99) < ((i < 300) ? 75 : 35));
      r  = ($urandom_range(0, 99) < ((i < 300) ? 35 : 75));
      c  = ($urandom_range(0, 99) < 10);
      rs = ($urandom_range(0, 199) == 0);
      step(w, r, 8'($urandom_range(0, 255)), c, rs);
    end

    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h30 + i), 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(1, 0, 8'h77, 0, 0);
    step(1, 0, 8'h99, 0, 1);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
